tpu_act_stream_engine: RTL and testbench
========================================

# tpu_act_stream_engine

Parametrised, double-buffered activation store and row streamer that feeds the systolic array's west edge. Successor to the fixed 64-column activation path: array width, depth and stride are generic. It adds valid/ready backpressure, strided and repeated passes, and deferred bank swaps. An optional diagonal skew stage removes the external skew network.

## Interface
- ARRAY_SIZE, 64, columns per row (≥1)
- ACT_BITS, 16, bits per activation
- DEPTH, 4096, rows per bank set (power of two); AW = $clog2(DEPTH)
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write one row into the shadow set
- wr_addr  in  AW  row address
- wr_data  in  ARRAY_SIZE*ACT_BITS  row data; column c at bits [c*ACT_BITS +: ACT_BITS]
- swap_req  in  1  request an active/shadow exchange
- swap_ack  out  1  one-cycle pulse when the swap has taken effect
- start  in  1  launch a stream; sampled only in IDLE
- base  in  AW  first row address
- count  in  AW+1  rows per pass (0 to DEPTH)
- stride  in  AW  address increment
- passes  in  8  pass repeat count; 0 is treated as 1
- busy  out  1  high in every state other than IDLE
- out_valid  out  1  row available
- out_ready  in  1  consumer accepts the row
- out_data  out  ARRAY_SIZE*ACT_BITS  streamed row
- out_last  out  1  final row of the final pass
- done  out  1  one-cycle completion pulse
- start_drop_count  out  16  starts ignored while busy; saturates at 0xFFFF

## Operation
- Two bank sets, each DEPTH × ARRAY_SIZE*ACT_BITS. active_set resets to 0.
- Writes always go to set ~active_set, using the active_set value from before the clock edge.
- Writes are legal in every state.
- Row address sequence: addr_i = (base + i*stride) mod DEPTH, for i = 0..count-1.
  - The sequence restarts at base for each pass.
  - The total is count*passes rows.
- FSM states: IDLE, STREAM, DRAIN, DONE.
  - IDLE→STREAM on start when count≠0.
  - IDLE→DONE on start when count=0.
  - STREAM→DRAIN after the last read is issued.
  - DRAIN→DONE on the handshake of the out_last row.
  - DONE→IDLE unconditionally.
- Reads are synchronous (1-cycle RAM) into an internal 2-entry output FIFO.
  - A read is issued only when FIFO occupancy plus in-flight reads is less than 2.
  - No row is ever lost or duplicated under backpressure.
- out_data, out_valid and out_last come straight from the FIFO head.
- Handshake rules:
  - A row transfers when out_valid && out_ready.
  - While out_valid is high and out_ready is low, out_data and out_last hold stable.
- Swap behaviour:
  - swap_req in IDLE toggles active_set at that edge; swap_ack pulses in the next cycle.
  - swap_req while busy sets a pending flag; further requests merge into it.
  - A pending swap executes on the DONE→IDLE edge.
- Simultaneous swap_req and start in IDLE: the swap executes first, and the stream reads the new active set.
- start while busy is ignored and increments start_drop_count.
- Reset mid-operation:
  - FSM returns to IDLE; FIFO is emptied; pending swap is cleared; active_set returns to 0.
  - RAM contents are not cleared.
- Reset values: all outputs are 0.

## Timing
- Start sampled at edge T: first read issues in cycle T+1; out_valid rises in cycle T+2.
- With out_ready held high: one row per cycle, no bubbles, across passes and across the wrap-around.
- done is high in the cycle after the out_last handshake; busy falls in the cycle after that.
- count=0: done pulses in cycle T+1; out_valid never rises.
- Backpressure recovery: the first row is delivered in the same cycle out_ready rises, with no refill penalty.

## Configuration
- TPU_ACT_SKEW_EN defined:
  - Column c of out_data carries the column-c element of row k−c; the element is 0 when k−c is out of range.
  - Each pass emits count+ARRAY_SIZE−1 rows, including zero-filled flush rows.
  - Skew registers advance only on handshakes.
  - out_last marks the final flush row of the last pass.
- TPU_ACT_SKEW_EN undefined: rows are emitted unskewed; count rows per pass.

## Test plan
- Write rows 0..7 of the shadow set, swap, start base=0, count=8, stride=1, out_ready=1 → rows 0..7 on cycles T+2..T+9; out_last on row 7; done at T+10.
- base=DEPTH−2, count=4, stride=1 → address sequence DEPTH−2, DEPTH−1, 0, 1.
- Stride 3 with passes=2 → rows from addresses 0, 3, 6 emitted twice; out_last only on the 6th row.
- Toggle out_ready randomly on a 16-row stream → all 16 rows delivered exactly once, in order, and stable while stalled.
- swap_req mid-stream plus a second start mid-stream → stream still reads the old set; start_drop_count=1; swap_ack pulses one cycle after done.
- Skew build with ARRAY_SIZE=4, count=2 → 5 rows per pass, diagonal placement, zero fill; assert rst_n mid-stream → all outputs return to 0.

Source files
------------

// File: rtl/tpu_act_stream_engine_if.sv
// Host-side bundle for tpu_act_stream_engine: shadow-row writes, bank swap,
// stream launch/configuration and the west-edge output stream.
interface tpu_act_stream_engine_if #(
  parameter int ARRAY_SIZE = 64,
  parameter int ACT_BITS   = 16,
  parameter int DEPTH      = 4096
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = ARRAY_SIZE * ACT_BITS;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          swap_req;
  logic          swap_ack;
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   count;
  logic [AW-1:0] stride;
  logic [7:0]    passes;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          done;
  logic [15:0]   start_drop_count;

  modport master (
    output wr_en, wr_addr, wr_data, swap_req, start, base, count, stride, passes, out_ready,
    input  swap_ack, busy, out_valid, out_data, out_last, done, start_drop_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, swap_req, start, base, count, stride, passes, out_ready,
    output swap_ack, busy, out_valid, out_data, out_last, done, start_drop_count
  );
endinterface

// File: rtl/tpu_act_stream_engine.sv
// Double-buffered activation store streaming strided, repeated row passes to the array's west edge.
// Optional diagonal skew stage enabled by defining TPU_ACT_SKEW_EN.
module tpu_act_stream_engine #(
  parameter int ARRAY_SIZE = 64,
  parameter int ACT_BITS   = 16,
  parameter int DEPTH      = 4096
) (
  input logic                  clk,
  input logic                  rst_n,
  tpu_act_stream_engine_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = ARRAY_SIZE * ACT_BITS;
  localparam int RW = $clog2(DEPTH + ARRAY_SIZE) + 1;
`ifdef TPU_ACT_SKEW_EN
  localparam int FLUSH_ROWS = ARRAY_SIZE - 1;
`else
  localparam int FLUSH_ROWS = 0;
`endif

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
  state_t state_reg, state_next;

  logic          active_set_reg, swap_pending_reg, swap_ack_reg;
  logic [15:0]   drop_count_reg;
  logic [AW-1:0] base_reg, stride_reg, addr_reg;
  logic [RW-1:0] count_reg, rows_reg, row_idx_reg;
  logic [7:0]    passes_reg, pass_idx_reg;

  logic [W-1:0]  ram [2*DEPTH];
  logic [W-1:0]  rd_data_reg;

  // Two-slot output FIFO: the RAM output register is the newer slot, s_* the older.
  logic          s_valid_reg, s_last_reg;
  logic [W-1:0]  s_data_reg;
  logic          r_valid_reg, r_last_reg, r_flush_reg;
  logic [W-1:0]  r_data, head_data;
  logic          head_last, out_valid_int;

  logic pop, issue, row_end, issue_last, issue_flush, r_to_s;

  assign r_data        = r_flush_reg ? '0 : rd_data_reg;
  assign head_data     = s_valid_reg ? s_data_reg : r_data;
  assign head_last     = s_valid_reg ? s_last_reg : r_last_reg;
  assign out_valid_int = s_valid_reg || r_valid_reg;

  assign pop         = out_valid_int && bus.out_ready;
  assign issue       = (state_reg == STREAM) && !(s_valid_reg && r_valid_reg && !pop);
  assign row_end     = (row_idx_reg == rows_reg - RW'(1));
  assign issue_last  = row_end && (pass_idx_reg == passes_reg - 8'd1);
  assign issue_flush = (row_idx_reg >= count_reg);
  assign r_to_s      = r_valid_reg && issue && !(pop && !s_valid_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = (bus.count == '0) ? DONE : STREAM;
      STREAM:  if (issue && issue_last) state_next = DRAIN;
      DRAIN:   if (pop && head_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Writes target the shadow set as seen before this edge; RAM is never reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en) ram[{~active_set_reg, bus.wr_addr}] <= bus.wr_data;
    if (issue)     rd_data_reg <= ram[{active_set_reg, addr_reg}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_reg     <= '0;
      stride_reg   <= '0;
      addr_reg     <= '0;
      count_reg    <= '0;
      rows_reg     <= '0;
      row_idx_reg  <= '0;
      passes_reg   <= 8'd1;
      pass_idx_reg <= '0;
    end else if (state_reg == IDLE && bus.start) begin
      base_reg     <= bus.base;
      stride_reg   <= bus.stride;
      addr_reg     <= bus.base;
      count_reg    <= RW'(bus.count);
      rows_reg     <= RW'(bus.count) + RW'(FLUSH_ROWS);
      row_idx_reg  <= '0;
      passes_reg   <= (bus.passes == 8'd0) ? 8'd1 : bus.passes;
      pass_idx_reg <= '0;
    end else if (issue) begin
      if (row_end) begin
        row_idx_reg  <= '0;
        pass_idx_reg <= pass_idx_reg + 8'd1;
        addr_reg     <= base_reg;
      end else begin
        row_idx_reg  <= row_idx_reg + RW'(1);
        addr_reg     <= addr_reg + stride_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid_reg <= 1'b0;
      s_last_reg  <= 1'b0;
      s_data_reg  <= '0;
      r_valid_reg <= 1'b0;
      r_last_reg  <= 1'b0;
      r_flush_reg <= 1'b0;
    end else begin
      if (r_to_s) begin
        s_valid_reg <= 1'b1;
        s_last_reg  <= r_last_reg;
        s_data_reg  <= r_data;
      end else if (pop && s_valid_reg) begin
        s_valid_reg <= 1'b0;
      end
      if (issue) begin
        r_valid_reg <= 1'b1;
        r_last_reg  <= issue_last;
        r_flush_reg <= issue_flush;
      end else if (pop && !s_valid_reg) begin
        r_valid_reg <= 1'b0;
      end
    end
  end

  // A swap seen while busy is deferred to the DONE->IDLE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_set_reg   <= 1'b0;
      swap_pending_reg <= 1'b0;
      swap_ack_reg     <= 1'b0;
      drop_count_reg   <= '0;
    end else begin
      swap_ack_reg <= 1'b0;
      if (state_reg == IDLE && bus.swap_req) begin
        active_set_reg <= ~active_set_reg;
        swap_ack_reg   <= 1'b1;
      end else if (state_reg == DONE && (swap_pending_reg || bus.swap_req)) begin
        active_set_reg   <= ~active_set_reg;
        swap_ack_reg     <= 1'b1;
        swap_pending_reg <= 1'b0;
      end else if (state_reg != IDLE && bus.swap_req) begin
        swap_pending_reg <= 1'b1;
      end
      if (state_reg != IDLE && bus.start && drop_count_reg != 16'hFFFF)
        drop_count_reg <= drop_count_reg + 16'd1;
    end
  end

`ifdef TPU_ACT_SKEW_EN
  // Column c is delayed by c accepted rows; flush rows shift zeros in behind each pass.
  logic [W-1:0] skew_data;
  for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_col
    if (gi == 0) begin : g_direct
      assign skew_data[0 +: ACT_BITS] = head_data[0 +: ACT_BITS];
    end else begin : g_delay
      logic [ACT_BITS-1:0] dl_reg [gi];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < gi; j++) dl_reg[j] <= '0;
        end else if (pop) begin
          dl_reg[0] <= head_data[gi*ACT_BITS +: ACT_BITS];
          for (int j = 1; j < gi; j++) dl_reg[j] <= dl_reg[j-1];
        end
      end
      assign skew_data[gi*ACT_BITS +: ACT_BITS] = dl_reg[gi-1];
    end
  end
  assign bus.out_data = out_valid_int ? skew_data : '0;
`else
  assign bus.out_data = out_valid_int ? head_data : '0;
`endif

  assign bus.out_valid        = out_valid_int;
  assign bus.out_last         = out_valid_int && head_last;
  assign bus.busy             = (state_reg != IDLE);
  assign bus.done             = (state_reg == DONE);
  assign bus.swap_ack         = swap_ack_reg;
  assign bus.start_drop_count = drop_count_reg;
endmodule

// File: tb/tb_tpu_act_stream_engine.sv
// Directed bench for tpu_act_stream_engine: timing, wrap, stride/passes, backpressure,
// deferred swap, dropped starts, count=0 and asynchronous reset (skew-aware expectations).
`timescale 1ns/1ps
module tb_tpu_act_stream_engine;
  localparam int AS    = 4;
  localparam int AB    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = AW + 1;
  localparam int W     = AS * AB;
`ifdef TPU_ACT_SKEW_EN
  localparam int SKEW_EXTRA = AS - 1;
`else
  localparam int SKEW_EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   exp_addr[$];
  logic exp_set;

  always #5 clk = ~clk;

  tpu_act_stream_engine_if #(.ARRAY_SIZE(AS), .ACT_BITS(AB), .DEPTH(DEPTH)) bus_if ();
  tpu_act_stream_engine #(.ARRAY_SIZE(AS), .ACT_BITS(AB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // Row content is unique per (set, address, column).
  function automatic logic [W-1:0] row_val(input logic s, input int a);
    logic [W-1:0] r;
    for (int c = 0; c < AS; c++) r[c*AB +: AB] = 8'(int'(s) * 128 + a * 4 + c);
    return r;
  endfunction

  function automatic logic [W-1:0] exp_row(input int g);
    int cnt = exp_addr.size();
    int k   = g % (cnt + SKEW_EXTRA);
    logic [W-1:0] r = '0;
    logic [W-1:0] src;
    for (int c = 0; c < AS; c++) begin
      int j;
      j = (SKEW_EXTRA != 0) ? k - c : k;
      if (j >= 0 && j < cnt) begin
        src = row_val(exp_set, exp_addr[j]);
        r[c*AB +: AB] = src[c*AB +: AB];
      end
    end
    return r;
  endfunction

  task automatic write_row(input int a, input logic [W-1:0] d);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = AW'(a);
    bus_if.wr_data = d;
    step();
    bus_if.wr_en   = 1'b0;
  endtask

  // mode 0: out_ready held high with per-cycle timing checks; mode 1: random out_ready.
  task automatic stream_check(input string tag, input int base, input int stride, input int passes,
                              input int n_pass, input int mode, input int inject_at, input bit with_swap);
    int cnt   = exp_addr.size();
    int total = (cnt + SKEW_EXTRA) * n_pass;
    int idx   = 0;
    int cyc   = 0;
    bit prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    bus_if.base     = AW'(base);
    bus_if.count    = CW'(cnt);
    bus_if.stride   = AW'(stride);
    bus_if.passes   = 8'(passes);
    bus_if.start    = 1'b1;
    bus_if.swap_req = with_swap;
    step();
    bus_if.start    = 1'b0;
    bus_if.swap_req = 1'b0;
    if (with_swap) begin
      exp_set = ~exp_set;
      check({tag, " swap_ack"}, bus_if.swap_ack, 1'b1);
    end
    check({tag, " busy T+1"}, bus_if.busy, 1'b1);
    check({tag, " valid T+1"}, bus_if.out_valid, 1'b0);
    step();
    while (idx < total && cyc < 400) begin
      bus_if.out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus_if.swap_req  = (cyc == inject_at);
      bus_if.start     = (cyc == inject_at);
      if (mode == 0) check({tag, " no bubble"}, bus_if.out_valid, 1'b1);
      if (prev_stall) begin
        check({tag, " stall data"}, bus_if.out_data, prev_data);
        check({tag, " stall last"}, bus_if.out_last, prev_last);
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        $display("%s row %0d data=%h last=%0b", tag, idx, bus_if.out_data, bus_if.out_last);
        check({tag, " data"}, bus_if.out_data, exp_row(idx));
        check({tag, " last"}, bus_if.out_last, (idx == total - 1));
        idx++;
      end
      prev_stall = bus_if.out_valid && !bus_if.out_ready;
      prev_data  = bus_if.out_data;
      prev_last  = bus_if.out_last;
      cyc++;
      step();
    end
    bus_if.swap_req  = 1'b0;
    bus_if.start     = 1'b0;
    bus_if.out_ready = 1'b0;
    check({tag, " rows delivered"}, idx, total);
    check({tag, " done"}, bus_if.done, 1'b1);
    step();
    check({tag, " busy fall"}, bus_if.busy, 1'b0);
    check({tag, " done pulse"}, bus_if.done, 1'b0);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus_if.wr_en     = 1'b0;
    bus_if.wr_addr   = '0;
    bus_if.wr_data   = '0;
    bus_if.swap_req  = 1'b0;
    bus_if.start     = 1'b0;
    bus_if.base      = '0;
    bus_if.count     = '0;
    bus_if.stride    = '0;
    bus_if.passes    = '0;
    bus_if.out_ready = 1'b0;
    exp_set          = 1'b0;
    step();
    step();
    check("reset busy", bus_if.busy, 1'b0);
    check("reset valid", bus_if.out_valid, 1'b0);
    check("reset data", bus_if.out_data, '0);
    check("reset last", bus_if.out_last, 1'b0);
    check("reset done", bus_if.done, 1'b0);
    check("reset swap_ack", bus_if.swap_ack, 1'b0);
    check("reset drops", bus_if.start_drop_count, 16'd0);
    rst_n = 1'b1;
    step();

    // Fill set 1 as shadow, swap it active, then fill set 0 as the new shadow.
    for (int a = 0; a < DEPTH; a++) write_row(a, row_val(1'b1, a));
    bus_if.swap_req = 1'b1;
    step();
    bus_if.swap_req = 1'b0;
    check("idle swap_ack", bus_if.swap_ack, 1'b1);
    exp_set = 1'b1;
    step();
    check("idle swap_ack pulse", bus_if.swap_ack, 1'b0);
    for (int a = 0; a < DEPTH; a++) write_row(a, row_val(1'b0, a));

    exp_addr = '{0, 1, 2, 3, 4, 5, 6, 7};
    stream_check("linear8", 0, 1, 1, 1, 0, -1, 1'b0);

    exp_addr = '{14, 15, 0, 1};
    stream_check("wrap", 14, 1, 0, 1, 0, -1, 1'b0);

    exp_addr = '{0, 3, 6};
    stream_check("stride3x2", 0, 3, 2, 2, 0, -1, 1'b0);

    exp_addr = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    stream_check("backpressure16", 0, 1, 1, 1, 1, -1, 1'b0);

    // Swap and a second start mid-stream: old set keeps streaming, swap lands after done.
    exp_addr = '{0, 1, 2, 3, 4, 5, 6, 7};
    stream_check("midswap", 0, 1, 1, 1, 0, 3, 1'b0);
    check("midswap swap_ack", bus_if.swap_ack, 1'b1);
    check("midswap drops", bus_if.start_drop_count, 16'd1);
    exp_set = 1'b0;
    step();
    check("midswap swap_ack pulse", bus_if.swap_ack, 1'b0);

    // count = 0: done in T+1 with no output.
    bus_if.count = '0;
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    check("count0 done", bus_if.done, 1'b1);
    check("count0 valid", bus_if.out_valid, 1'b0);
    step();
    check("count0 busy", bus_if.busy, 1'b0);
    check("count0 valid after", bus_if.out_valid, 1'b0);

    exp_addr = '{3, 4};
    stream_check("swap+start", 3, 1, 1, 1, 0, -1, 1'b1);

    // Asynchronous reset with a full FIFO.
    bus_if.base   = '0;
    bus_if.count  = CW'(8);
    bus_if.stride = AW'(1);
    bus_if.passes = 8'd1;
    bus_if.start  = 1'b1;
    step();
    bus_if.start  = 1'b0;
    bus_if.swap_req = 1'b1;
    step();
    bus_if.swap_req = 1'b0;
    step();
    step();
    check("prereset valid", bus_if.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midreset busy", bus_if.busy, 1'b0);
    check("midreset valid", bus_if.out_valid, 1'b0);
    check("midreset data", bus_if.out_data, '0);
    check("midreset last", bus_if.out_last, 1'b0);
    check("midreset done", bus_if.done, 1'b0);
    check("midreset drops", bus_if.start_drop_count, 16'd0);
    step();
    rst_n = 1'b1;
    exp_set = 1'b0;
    step();
    check("postreset swap_ack", bus_if.swap_ack, 1'b0);

    exp_addr = '{5, 6};
    stream_check("postreset set0", 5, 1, 1, 1, 0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
